// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline latches; times multi-cycle EX ops with a RUN/BUSY FSM.
// Outputs combinational from state and inputs (0 cycles); MEM wait freezes the multi-cycle countdown.
module pipeline_controller #(
    parameter int unsigned MULTI_LATENCY = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_rs_read,
    input  logic [4:0]  id_rs_address,
    input  logic        id_rt_read,
    input  logic [4:0]  id_rt_address,
    input  logic        ex_memory_read,
    input  logic [4:0]  ex_register_write_address,
    input  logic        ex_multicycle_start,
    input  logic        mem_stall_request,
    input  logic        mem_exception,
    input  logic [31:0] mem_exception_target,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        ex_multicycle_done,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [7:0] LOAD_COUNT = 8'(MULTI_LATENCY - 2);

    logic [0:0] r_state;
    logic [7:0] r_count;
    logic [0:0] w_state_nxt;
    logic [7:0] w_count_nxt;
    logic       w_ex_stall;
    logic       w_done;
    logic       w_load_use;

    assign w_load_use = ex_memory_read && (ex_register_write_address != 5'd0) &&
                        ((id_rs_read && (id_rs_address == ex_register_write_address)) ||
                         (id_rt_read && (id_rt_address == ex_register_write_address)));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ex_stall  = 1'b0;
        w_done      = 1'b0;
        if (mem_exception) begin
            w_state_nxt = S_RUN;
            w_count_nxt = 8'd0;
        end else if (r_state == S_RUN) begin
            if (ex_multicycle_start && !mem_stall_request) begin
                w_ex_stall  = 1'b1;
                w_state_nxt = S_BUSY;
                w_count_nxt = LOAD_COUNT;
            end
        end else if (r_count != 8'd0) begin
            w_ex_stall = 1'b1;
            if (!mem_stall_request) begin
                w_count_nxt = r_count - 8'd1;
            end
        end else if (!mem_stall_request) begin
            // Result is ready and MEM can accept it: the op leaves EX this cycle.
            w_done      = 1'b1;
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        stall              = 5'b00000;
        flush              = 5'b00000;
        ex_multicycle_done = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'd0;
        if (!reset) begin
            ex_multicycle_done = w_done;
            if (mem_exception) begin
                flush          = 5'b11110;
                redirect_valid = 1'b1;
                redirect_pc    = mem_exception_target;
            end else if (mem_stall_request) begin
                stall = 5'b01111;
                flush = 5'b10000;
            end else if (w_ex_stall) begin
                stall = 5'b00111;
                flush = 5'b01000;
            end else if (w_load_use) begin
                stall = 5'b00011;
                flush = 5'b00100;
            end
        end
    end

endmodule
